// File: rtl/fp_div.sv
// Single-precision floating-point divider: 26-cycle restoring mantissa divider with special-case bypass.
// Define FP_DIV_ROUND_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fp_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] I1,
  input  logic [31:0] I2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        divz
);

`ifdef FP_DIV_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_q, out_d;
  logic               divz_q, divz_d;
  logic [25:0]        q_q, q_d;
  logic [24:0]        rem_q, rem_d;
  logic [23:0]        m2_q, m2_d;
  logic [4:0]         cnt_q, cnt_d;
  logic signed [9:0]  exp_q, exp_d;
  logic               sign_q, sign_d;

  logic [7:0]  e1, e2;
  logic [22:0] f1, f2;
  logic        z1, z2, inf1, inf2, nan_any;
  logic        accept, special;
  logic [31:0] special_res;
  logic        special_divz;
  logic        res_sign;

  assign e1 = I1[30:23];
  assign e2 = I2[30:23];
  assign f1 = I1[22:0];
  assign f2 = I2[22:0];

  // Exponent zero covers denormals, which are flushed to signed zero.
  assign z1      = (e1 == 8'h00);
  assign z2      = (e2 == 8'h00);
  assign inf1    = (e1 == 8'hFF) && (f1 == 23'd0);
  assign inf2    = (e2 == 8'hFF) && (f2 == 23'd0);
  assign nan_any = ((e1 == 8'hFF) && (f1 != 23'd0)) || ((e2 == 8'hFF) && (f2 != 23'd0));

  assign accept   = in_valid && in_ready_q;
  assign special  = nan_any || z1 || z2 || inf1 || inf2;
  assign res_sign = I1[31] ^ I2[31];

  always_comb begin
    special_res  = {res_sign, 31'd0};
    special_divz = 1'b0;
    if (nan_any || (z1 && z2) || (inf1 && inf2)) begin
      special_res = 32'h7FC0_0000;
    end else if (inf1) begin
      special_res = {res_sign, 8'hFF, 23'd0};
    end else if (z2) begin
      special_res  = {res_sign, 8'hFF, 23'd0};
      special_divz = 1'b1;
    end
  end

  // Normalisation and optional rounding of the finished quotient.
  logic [22:0]       mant;
  logic              guard, sticky, round_up;
  logic signed [9:0] exp_n, exp_fin;
  logic [23:0]       mant_sum;
  logic [22:0]       mant_fin;
  logic [31:0]       norm_res;

  always_comb begin
    if (q_q[25]) begin
      mant   = q_q[24:2];
      guard  = q_q[1];
      sticky = q_q[0] | (rem_q != 25'd0);
      exp_n  = exp_q + 10'sd127;
    end else begin
      mant   = q_q[23:1];
      guard  = q_q[0];
      sticky = (rem_q != 25'd0);
      exp_n  = exp_q + 10'sd126;
    end
    round_up = guard & (sticky | mant[0]);
    mant_sum = {1'b0, mant} + {23'd0, ROUND_EN & round_up};
    if (mant_sum[23]) begin
      mant_fin = 23'd0;
      exp_fin  = exp_n + 10'sd1;
    end else begin
      mant_fin = mant_sum[22:0];
      exp_fin  = exp_n;
    end
    if (exp_fin >= 10'sd255) begin
      norm_res = {sign_q, 8'hFF, 23'd0};
    end else if (exp_fin <= 10'sd0) begin
      norm_res = {sign_q, 31'd0};
    end else begin
      norm_res = {sign_q, exp_fin[7:0], mant_fin};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= 32'd0;
      divz_q      <= 1'b0;
      q_q         <= 26'd0;
      rem_q       <= 25'd0;
      m2_q        <= 24'd0;
      cnt_q       <= 5'd0;
      exp_q       <= 10'sd0;
      sign_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      divz_q      <= divz_d;
      q_q         <= q_d;
      rem_q       <= rem_d;
      m2_q        <= m2_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = special ? DONE : DIVIDE;
      DIVIDE:  if (cnt_q == 5'd25) state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic        ge;
  logic [24:0] diff;

  // Handshake flags are registered from the next state so they stay low during reset.
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    out_d       = out_q;
    divz_d      = divz_q;
    q_d         = q_q;
    rem_d       = rem_q;
    m2_d        = m2_q;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    ge          = (rem_q >= {1'b0, m2_q});
    diff        = ge ? (rem_q - {1'b0, m2_q}) : rem_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d = res_sign;
          exp_d  = $signed({2'b00, e1}) - $signed({2'b00, e2});
          rem_d  = {2'b01, f1};
          m2_d   = {1'b1, f2};
          q_d    = 26'd0;
          cnt_d  = 5'd0;
          if (special) begin
            out_d  = special_res;
            divz_d = special_divz;
          end
        end
      end
      DIVIDE: begin
        q_d   = {q_q[24:0], ge};
        rem_d = diff << 1;
        cnt_d = cnt_q + 5'd1;
      end
      NORM: begin
        out_d  = norm_res;
        divz_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign divz      = divz_q;

endmodule
